// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-channel arbiter (round-robin or fixed priority) onto the single iomem block port,
// with a registered response path and an optional watchdog that completes stalled requests with an error.
module mem_arbiter_rr #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned STRB_W   = 16,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH-1:0]         ch_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]  ch_wdata_i,
    input  logic [NUM_CH*STRB_W-1:0]  ch_wstrb_i,
    output logic [NUM_CH-1:0]         ch_rvalid_o,
    output logic [DATA_W-1:0]         ch_rdata_o,
    output logic                      ch_err_o,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic [STRB_W-1:0]         mem_wstrb_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [$clog2(NUM_CH)-1:0] grant_o,
    output logic                      busy_o
);
    localparam int unsigned GNT_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    ptr_q, ptr_d;
    logic [GNT_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                rr_found, fp_found;
    logic [GNT_W-1:0]    rr_win, fp_win, rr_idx, win;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                timeout_hit;

    // Winner search: lowest set index (fixed) and first set index after ptr, wrapping (round-robin).
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = '0;
        fp_found = 1'b0;
        fp_win   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!fp_found && ch_valid_i[GNT_W'(i)]) begin
                fp_found = 1'b1;
                fp_win   = GNT_W'(i);
            end
        end
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            rr_idx = GNT_W'((32'(ptr_q) + i) % NUM_CH);
            if (!rr_found && ch_valid_i[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
        win = (ARB_MODE == 0) ? rr_win : fp_win;
    end

    // Request-field mux for the selected winner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (win == GNT_W'(c)) begin
                sel_addr  = ch_addr_i[c*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata_i[c*DATA_W +: DATA_W];
                sel_wstrb = ch_wstrb_i[c*STRB_W +: STRB_W];
            end
        end
    end

    // Watchdog fires on the last allowed REQ cycle; disabled entirely when TIMEOUT is zero.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|ch_valid_i) begin
                    grant_d = win;
                    if (ARB_MODE == 0) begin
                        ptr_d = win;
                    end
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    rdata_d = mem_rdata_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= GNT_W'(NUM_CH - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-hot completion pulse decoded from state and the latched grant.
    always_comb begin
        ch_rvalid_o = '0;
        if (state_q == RESP) begin
            ch_rvalid_o[grant_q] = 1'b1;
        end
    end

    assign mem_valid_o = (state_q == REQ);
    assign busy_o      = (state_q != IDLE);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign ch_rdata_o  = rdata_q;
    assign ch_err_o    = err_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter_rr;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 16;
    localparam int TO = 8;
    localparam int GW = 2;

    logic               clk;
    logic               rst;
    logic [NC-1:0]      ch_valid;
    logic [NC*AW-1:0]   ch_addr;
    logic [NC*DW-1:0]   ch_wdata;
    logic [NC*SW-1:0]   ch_wstrb;
    logic               mem_ready;
    logic [DW-1:0]      mem_rdata;

    logic [NC-1:0] rr_rvalid, fp_rvalid, o_rvalid;
    logic [DW-1:0] rr_rdata, fp_rdata, o_rdata;
    logic          rr_err, fp_err, o_err;
    logic          rr_mem_valid, fp_mem_valid, o_mem_valid;
    logic [AW-1:0] rr_mem_addr, fp_mem_addr, o_mem_addr;
    logic [DW-1:0] rr_mem_wdata, fp_mem_wdata, o_mem_wdata;
    logic [SW-1:0] rr_mem_wstrb, fp_mem_wstrb, o_mem_wstrb;
    logic [GW-1:0] rr_grant, fp_grant, o_grant;
    logic          rr_busy, fp_busy, o_busy;

    logic use_fp;
    int   errors;
    int   checks;

    mem_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .ARB_MODE(0), .TIMEOUT(TO)) u_rr (
        .clk_i(clk), .rst_i(rst), .ch_valid_i(ch_valid), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
        .ch_wstrb_i(ch_wstrb), .ch_rvalid_o(rr_rvalid), .ch_rdata_o(rr_rdata), .ch_err_o(rr_err),
        .mem_valid_o(rr_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(rr_mem_addr),
        .mem_wdata_o(rr_mem_wdata), .mem_wstrb_o(rr_mem_wstrb), .mem_rdata_i(mem_rdata),
        .grant_o(rr_grant), .busy_o(rr_busy));

    mem_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .ARB_MODE(1), .TIMEOUT(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .ch_valid_i(ch_valid), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
        .ch_wstrb_i(ch_wstrb), .ch_rvalid_o(fp_rvalid), .ch_rdata_o(fp_rdata), .ch_err_o(fp_err),
        .mem_valid_o(fp_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(fp_mem_addr),
        .mem_wdata_o(fp_mem_wdata), .mem_wstrb_o(fp_mem_wstrb), .mem_rdata_i(mem_rdata),
        .grant_o(fp_grant), .busy_o(fp_busy));

    // Observed outputs of whichever instance the current scenario targets.
    assign o_rvalid    = use_fp ? fp_rvalid    : rr_rvalid;
    assign o_rdata     = use_fp ? fp_rdata     : rr_rdata;
    assign o_err       = use_fp ? fp_err       : rr_err;
    assign o_mem_valid = use_fp ? fp_mem_valid : rr_mem_valid;
    assign o_mem_addr  = use_fp ? fp_mem_addr  : rr_mem_addr;
    assign o_mem_wdata = use_fp ? fp_mem_wdata : rr_mem_wdata;
    assign o_mem_wstrb = use_fp ? fp_mem_wstrb : rr_mem_wstrb;
    assign o_grant     = use_fp ? fp_grant     : rr_grant;
    assign o_busy      = use_fp ? fp_busy      : rr_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        ch_addr[c*AW +: AW]  = a;
        ch_wdata[c*DW +: DW] = d;
        ch_wstrb[c*SW +: SW] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_valid = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        rst = 1'b0;
    endtask

    // Arbitration rule: fixed = lowest set index; round-robin = first set index after last winner.
    function automatic int pick(input logic [NC-1:0] v, input int last, input bit fixed);
        if (fixed) begin
            for (int i = 0; i < NC; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= NC; k++) if (v[(last + k) % NC]) return (last + k) % NC;
        end
        return 0;
    endfunction

    task automatic test_reset();
        logic [DW-1:0] r;
        use_fp = 1'b0;
        do_reset();
        r = rnd_data() | 128'h1;
        set_ch(0, 32'h0000_1000, rnd_data(), '0);
        set_ch(1, 32'h0000_2000, rnd_data() | 128'h1, 16'hFFFF);
        ch_valid = 4'b0001; mem_ready = 1'b1; mem_rdata = r;
        step(); step();
        ch_valid = 4'b0010; mem_ready = 1'b0;
        step(); step();
        rst = 1'b1; ch_valid = '0;
        step();
        rst = 1'b0;
        checks++; if (rr_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got=%b exp=0", rr_mem_valid); end
        checks++; if (rr_rvalid !== 4'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0000", rr_rvalid); end
        checks++; if (rr_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", rr_err); end
        checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", rr_busy); end
        checks++; if (rr_grant !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d exp=0", rr_grant); end
        checks++; if (rr_rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rr_rdata); end
        checks++; if (rr_mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", rr_mem_addr); end
        checks++; if (rr_mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", rr_mem_wdata); end
        checks++; if (rr_mem_wstrb !== '0) begin errors++; $display("FAIL rst_mem_wstrb got=%h exp=0", rr_mem_wstrb); end
        checks++; if (fp_mem_valid !== 1'b0 || fp_busy !== 1'b0) begin errors++; $display("FAIL rst_fp_state valid=%b busy=%b exp=0,0", fp_mem_valid, fp_busy); end
        checks++; if (fp_grant !== 2'd0 || fp_rdata !== '0) begin errors++; $display("FAIL rst_fp_regs grant=%0d rdata=%h exp=0,0", fp_grant, fp_rdata); end
    endtask

    task automatic test_single_read();
        logic [DW-1:0] r;
        use_fp = 1'b0;
        do_reset();
        r = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
        set_ch(0, 32'h8000_0040, '0, '0);
        ch_valid = 4'b0001;
        step();
        checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL rd_mem_valid got=%b exp=1", o_mem_valid); end
        checks++; if (o_mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL rd_mem_addr got=%h exp=80000040", o_mem_addr); end
        checks++; if (o_mem_wstrb !== 16'h0) begin errors++; $display("FAIL rd_mem_wstrb got=%h exp=0000", o_mem_wstrb); end
        mem_ready = 1'b1; mem_rdata = r;
        step();
        checks++; if (o_rvalid !== 4'b0001) begin errors++; $display("FAIL rd_rvalid got=%b exp=0001", o_rvalid); end
        checks++; if (o_rdata !== r) begin errors++; $display("FAIL rd_rdata got=%h exp=%h", o_rdata, r); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", o_err); end
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rd_mem_valid_resp got=%b exp=0", o_mem_valid); end
        ch_valid = '0; mem_ready = 1'b0;
        step();
        checks++; if (o_busy !== 1'b0 || o_rvalid !== 4'b0) begin errors++; $display("FAIL rd_idle busy=%b rvalid=%b exp=0,0000", o_busy, o_rvalid); end
    endtask

    task automatic test_rr_fairness();
        int n, last, prev, exp_ch;
        logic [NC-1:0] exp_rv;
        use_fp = 1'b0;
        do_reset();
        for (int c = 0; c < NC; c++) set_ch(c, $urandom(), rnd_data(), '0);
        ch_valid = 4'hF; mem_ready = 1'b1; mem_rdata = rnd_data();
        n = 0; last = NC - 1; prev = -1;
        for (int cyc = 1; cyc <= 40 && n < 5; cyc++) begin
            step();
            if (o_rvalid !== 4'b0) begin
                exp_ch = pick(4'hF, last, 1'b0);
                exp_rv = 4'(1 << exp_ch);
                checks++; if (o_rvalid !== exp_rv) begin errors++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, o_rvalid, exp_rv); end
                if (prev >= 0) begin
                    checks++; if (cyc - prev != 3) begin errors++; $display("FAIL rr_spacing n=%0d got=%0d exp=3", n, cyc - prev); end
                end
                prev = cyc; last = exp_ch; n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", n); end
        ch_valid = '0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_fixed_priority();
        int n;
        int order [3];
        int exp_order [3];
        logic [AW-1:0] a1;
        use_fp = 1'b1;
        do_reset();
        a1 = $urandom();
        set_ch(0, $urandom(), rnd_data(), '0);
        set_ch(1, a1, rnd_data(), '0);
        set_ch(3, $urandom(), rnd_data(), '0);
        ch_valid = 4'b1010; mem_ready = 1'b0;
        step();
        checks++; if (o_grant !== 2'd1 || o_mem_valid !== 1'b1) begin errors++; $display("FAIL fp_first grant=%0d valid=%b exp=1,1", o_grant, o_mem_valid); end
        checks++; if (o_mem_addr !== a1) begin errors++; $display("FAIL fp_addr got=%h exp=%h", o_mem_addr, a1); end
        ch_valid = ch_valid | 4'b0001;
        step(); step();
        mem_ready = 1'b1;
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 3;
        for (int i = 0; i < 3; i++) order[i] = -1;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            step();
            if (o_rvalid !== 4'b0) begin
                for (int c = 0; c < NC; c++) if (o_rvalid[c]) order[n] = c;
                n++;
                ch_valid = ch_valid & ~o_rvalid;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL fp_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
        end
        ch_valid = '0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_write_hold();
        logic [AW-1:0] a1;
        logic [DW-1:0] w1, r;
        use_fp = 1'b0;
        do_reset();
        a1 = $urandom(); w1 = rnd_data(); r = rnd_data();
        set_ch(1, a1, w1, 16'h00F0);
        ch_valid = 4'b0010; mem_ready = 1'b0;
        step();
        checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL wr_grant got=%0d exp=1", o_grant); end
        checks++; if (o_mem_wdata !== w1) begin errors++; $display("FAIL wr_wdata got=%h exp=%h", o_mem_wdata, w1); end
        for (int i = 0; i < 5; i++) begin
            ch_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
            ch_wstrb = {$urandom(), $urandom()};
            step();
            checks++; if (o_mem_addr !== a1) begin errors++; $display("FAIL wr_hold_addr i=%0d got=%h exp=%h", i, o_mem_addr, a1); end
            checks++; if (o_mem_wstrb !== 16'h00F0) begin errors++; $display("FAIL wr_hold_strb i=%0d got=%h exp=00f0", i, o_mem_wstrb); end
            checks++; if (o_rvalid !== 4'b0) begin errors++; $display("FAIL wr_early_rvalid i=%0d got=%b exp=0000", i, o_rvalid); end
        end
        mem_ready = 1'b1; mem_rdata = r;
        step();
        checks++; if (o_rvalid !== 4'b0010) begin errors++; $display("FAIL wr_rvalid got=%b exp=0010", o_rvalid); end
        checks++; if (o_err !== 1'b0 || o_rdata !== r) begin errors++; $display("FAIL wr_resp err=%b rdata=%h exp=0,%h", o_err, o_rdata, r); end
        ch_valid = '0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n_req;
        logic [DW-1:0] r0, r2;
        use_fp = 1'b0;
        do_reset();
        r0 = rnd_data() | 128'h1; r2 = rnd_data();
        set_ch(0, $urandom(), rnd_data(), '0);
        set_ch(1, $urandom(), rnd_data(), '0);
        ch_valid = 4'b0001; mem_ready = 1'b1; mem_rdata = r0;
        step(); step();
        ch_valid = '0; mem_ready = 1'b0;
        step();
        ch_valid = 4'b0010;
        step();
        n_req = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (o_rvalid !== 4'b0) break;
            if (o_mem_valid === 1'b1) n_req++;
            step();
        end
        checks++; if (o_rvalid !== 4'b0010) begin errors++; $display("FAIL to_rvalid got=%b exp=0010", o_rvalid); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", o_err); end
        checks++; if (o_rdata !== '0) begin errors++; $display("FAIL to_rdata got=%h exp=0", o_rdata); end
        checks++; if (n_req != TO) begin errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", n_req, TO); end
        ch_valid = '0;
        step();
        ch_valid = 4'b0010;
        step();
        for (int i = 0; i < TO - 1; i++) begin
            checks++; if (o_rvalid !== 4'b0) begin errors++; $display("FAIL to2_early i=%0d got=%b exp=0000", i, o_rvalid); end
            step();
        end
        checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL to2_req8 got=%b exp=1", o_mem_valid); end
        mem_ready = 1'b1; mem_rdata = r2;
        step();
        checks++; if (o_rvalid !== 4'b0010 || o_err !== 1'b0) begin errors++; $display("FAIL to2_race rvalid=%b err=%b exp=0010,0", o_rvalid, o_err); end
        checks++; if (o_rdata !== r2) begin errors++; $display("FAIL to2_rdata got=%h exp=%h", o_rdata, r2); end
        ch_valid = '0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a0;
        use_fp = 1'b0;
        do_reset();
        a0 = $urandom();
        set_ch(0, a0, rnd_data(), '0);
        set_ch(1, $urandom(), rnd_data(), '0);
        ch_valid = 4'b0010; mem_ready = 1'b0;
        step();
        checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL rm_grant1 got=%0d exp=1", o_grant); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (o_mem_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rm_abort valid=%b busy=%b exp=0,0", o_mem_valid, o_busy); end
        checks++; if (o_rvalid !== 4'b0) begin errors++; $display("FAIL rm_no_rvalid got=%b exp=0000", o_rvalid); end
        ch_valid = 4'b0011;
        step();
        checks++; if (o_grant !== 2'd0 || o_mem_addr !== a0) begin errors++; $display("FAIL rm_regrant grant=%0d addr=%h exp=0,%h", o_grant, o_mem_addr, a0); end
        mem_ready = 1'b1;
        step();
        checks++; if (o_rvalid !== 4'b0001) begin errors++; $display("FAIL rm_rvalid got=%b exp=0001", o_rvalid); end
        ch_valid = '0; mem_ready = 1'b0;
        step();
    endtask

    // Randomized requesters and memory; expected behaviour tracked per transaction phase.
    task automatic test_random(input bit fp);
        int phase, last, m_ch, m_wait;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata;
        logic [SW-1:0] m_wstrb;
        logic          m_err;
        logic [NC-1:0] done, exp_rv;
        use_fp = fp;
        do_reset();
        phase = 0; last = NC - 1; m_ch = 0; m_wait = 0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0; done = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if (!ch_valid[c] && !done[c] && $urandom_range(0, 3) == 0) begin
                    set_ch(c, $urandom(), rnd_data(), ($urandom_range(0, 1) == 1) ? 16'($urandom()) : 16'h0);
                    ch_valid[c] = 1'b1;
                end
            end
            done = '0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = rnd_data();
            case (phase)
                0: if (ch_valid != '0) begin
                    m_ch = pick(ch_valid, last, fp);
                    if (!fp) last = m_ch;
                    m_addr  = ch_addr[m_ch*AW +: AW];
                    m_wdata = ch_wdata[m_ch*DW +: DW];
                    m_wstrb = ch_wstrb[m_ch*SW +: SW];
                    m_wait = 0; phase = 1;
                end
                1: if (mem_ready) begin
                    m_rdata = mem_rdata; m_err = 1'b0; phase = 2;
                end else if (!fp && m_wait == TO - 1) begin
                    m_rdata = '0; m_err = 1'b1; phase = 2;
                end else begin
                    m_wait++;
                end
                default: phase = 0;
            endcase
            step();
            exp_rv = (phase == 2) ? 4'(1 << m_ch) : 4'b0;
            checks++; if (o_mem_valid !== (phase == 1)) begin errors++; $display("FAIL rnd_mem_valid cyc=%0d got=%b exp=%0d", cyc, o_mem_valid, phase == 1); end
            checks++; if (o_busy !== (phase != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%0d", cyc, o_busy, phase != 0); end
            checks++; if (o_rvalid !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, o_rvalid, exp_rv); end
            if (phase != 0) begin
                checks++; if (o_grant !== GW'(m_ch)) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, o_grant, m_ch); end
            end
            if (phase == 1) begin
                checks++; if (o_mem_addr !== m_addr || o_mem_wstrb !== m_wstrb || o_mem_wdata !== m_wdata) begin
                    errors++; $display("FAIL rnd_req cyc=%0d addr=%h strb=%h exp=%h,%h", cyc, o_mem_addr, o_mem_wstrb, m_addr, m_wstrb);
                end
            end
            if (phase == 2) begin
                checks++; if (o_rdata !== m_rdata || o_err !== m_err) begin
                    errors++; $display("FAIL rnd_resp cyc=%0d rdata=%h err=%b exp=%h,%b", cyc, o_rdata, o_err, m_rdata, m_err);
                end
                ch_valid[m_ch] = 1'b0;
                done[m_ch] = 1'b1;
            end
        end
        ch_valid = '0; mem_ready = 1'b0;
        step(); step();
    endtask

    initial begin
        errors = 0; checks = 0; use_fp = 1'b0;
        rst = 1'b1; ch_valid = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_fixed_priority();
        test_write_hold();
        test_timeout();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

endmodule
